// File: rtl/score_display.sv
// score_display: BCD score counter with a frame-synchronous snapshot and a
// 2-stage pixel renderer that draws the snapshot as scaled 16x32 glyphs.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   x, y              : current VGA pixel coordinate
//   pos_x, pos_y      : top-left corner of the most significant digit
//   enable            : drawing enable (pipelined with the pixel)
//   inc, clr          : score increment (one per cycle high), synchronous clear
//   r, g, b, hit      : pixel colour and lit-glyph flag, 2 cycles after x/y
//   score, sat        : live BCD score (MS digit in top nibble), saturation flag
module score_display #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned BLANK_LZ   = 1,
  parameter logic [7:0]  FG_R       = 8'hFF,
  parameter logic [7:0]  FG_G       = 8'hFF,
  parameter logic [7:0]  FG_B       = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic                  enable,
  input  logic                  inc,
  input  logic                  clr,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  output logic                  hit,
  output logic [DIGITS*4-1:0]   score,
  output logic                  sat
);

  localparam int unsigned SW     = DIGITS * 4;
  localparam int unsigned CELL_W = 16 << SCALE_LOG2;
  localparam int unsigned CELL_H = 32 << SCALE_LOG2;
  localparam int unsigned SPAN_W = DIGITS * CELL_W;
  localparam int unsigned CW     = 11;
  localparam int unsigned IDX_W  = 3;

  // Outlined seven-segment style glyph ROM; column 0 is the leftmost pixel.
  // Segment order {a,b,c,d,e,f,g}; '1' is a centre bar on a full-width base.
  function automatic logic glyph_bit(input logic [3:0] d,
                                     input logic [4:0] row,
                                     input logic [3:0] col);
    logic [6:0] seg;
    logic       one;
    logic       top, bot, mid, lft, rgt, upr, lwr;
    seg = '0;
    one = 1'b0;
    top = (row <= 5'd1);
    bot = (row >= 5'd30);
    mid = (row == 5'd15) || (row == 5'd16);
    lft = (col <= 4'd1);
    rgt = (col >= 4'd14);
    upr = (row <= 5'd16);
    lwr = (row >= 5'd15);
    case (d)
      4'd0: seg = 7'b1111110;
      4'd1: one = 1'b1;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    glyph_bit = (seg[6] && top) || (seg[5] && rgt && upr) ||
                (seg[4] && rgt && lwr) || (seg[3] && bot) ||
                (seg[2] && lft && lwr) || (seg[1] && lft && upr) ||
                (seg[0] && mid) ||
                (one && ((row == 5'd31) ||
                         ((row != 5'd0) && ((col == 4'd7) || (col == 4'd8)))));
  endfunction

  // BCD +1 with ripple carry; all_nines means the increment would overflow
  logic [SW-1:0] score_inc;
  logic          all_nines;

  always_comb begin
    logic carry;
    score_inc = score;
    carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score[i*4 +: 4] == 4'd9) begin
          score_inc[i*4 +: 4] = 4'd0;
        end else begin
          score_inc[i*4 +: 4] = score[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  // Live score; clear wins over increment, saturation freezes at all nines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      score <= '0;
      sat   <= 1'b0;
    end else if (inc && !sat) begin
      if (all_nines) sat   <= 1'b1;
      else           score <= score_inc;
    end
  end

  // Frame-start snapshot so a whole frame renders one consistent value
  logic [SW-1:0] snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        snap <= '0;
    else if (x == 10'd0 && y == 10'd0) snap <= score;
  end

  // Leading-zero blanking mask, index 0 = most significant digit
  logic [DIGITS-1:0] blank;

  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      lead     = lead && (snap[(DIGITS-1-i)*4 +: 4] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && lead && (i != DIGITS - 1);
    end
  end

  // Stage 1 geometry at 11 bits so pos+extent never wraps into a false hit
  logic [CW-1:0] x_w, y_w, px_w, py_w, dx, dy;
  logic          in_cell_c;

  assign x_w  = CW'(x);
  assign y_w  = CW'(y);
  assign px_w = CW'(pos_x);
  assign py_w = CW'(pos_y);
  assign dx   = x_w - px_w;
  assign dy   = y_w - py_w;
  assign in_cell_c = (x_w >= px_w) && (x_w < px_w + CW'(SPAN_W)) &&
                     (y_w >= py_w) && (y_w < py_w + CW'(CELL_H));

  logic             s1_in, s1_en;
  logic [IDX_W-1:0] s1_idx;
  logic [4:0]       s1_row;
  logic [3:0]       s1_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_in  <= 1'b0;
      s1_en  <= 1'b0;
      s1_idx <= '0;
      s1_row <= '0;
      s1_col <= '0;
    end else begin
      s1_in  <= in_cell_c;
      s1_en  <= enable;
      s1_idx <= IDX_W'(dx >> (4 + SCALE_LOG2));
      s1_row <= 5'(dy >> SCALE_LOG2);
      s1_col <= 4'(dx >> SCALE_LOG2);
    end
  end

  // Stage 2 digit select; an out-of-range index behaves as a blanked digit
  logic [3:0] digit_c;
  logic       blank_c;
  logic       hit_c;

  always_comb begin
    digit_c = 4'hF;
    blank_c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (s1_idx == IDX_W'(i)) begin
        digit_c = snap[(DIGITS-1-i)*4 +: 4];
        blank_c = blank[i];
      end
    end
    hit_c = s1_en && s1_in && !blank_c && glyph_bit(digit_c, s1_row, s1_col);
  end

  // ROM lookup and qualification resolve into the stage-2 output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit <= 1'b0;
      r   <= 8'd0;
      g   <= 8'd0;
      b   <= 8'd0;
    end else begin
      hit <= hit_c;
      r   <= hit_c ? FG_R : 8'd0;
      g   <= hit_c ? FG_G : 8'd0;
      b   <= hit_c ? FG_B : 8'd0;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: counting, saturation, tearing,
// table-driven glyph/geometry vectors, streaming latency and async reset.
module tb_score_display;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x, y, pos_x, pos_y;
  logic        enable, inc, clr;
  logic [7:0]  r, g, b, r0, g0, b0;
  logic        hit, hit0, sat, sat0;
  logic [15:0] score, score0;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  score_display u_dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y),
    .enable(enable), .inc(inc), .clr(clr),
    .r(r), .g(g), .b(b), .hit(hit), .score(score), .sat(sat)
  );

  score_display #(.BLANK_LZ(0)) u_nolz (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y),
    .enable(enable), .inc(inc), .clr(clr),
    .r(r0), .g(g0), .b(b0), .hit(hit0), .score(score0), .sat(sat0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] set;
    logic [9:0]  x, y, px, py;
    logic        en;
    logic        h1;
    logic        h0;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic [15:0] set, input int unsigned vx,
                              input int unsigned vy, input int unsigned px,
                              input int unsigned py, input logic en,
                              input logic h1, input logic h0);
    vec_t v;
    v.set = set; v.x = 10'(vx); v.y = 10'(vy); v.px = 10'(px); v.py = 10'(py);
    v.en = en; v.h1 = h1; v.h0 = h0;
    tv.push_back(v);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_incs(input int unsigned n);
    inc = 1'b1;
    repeat (n) tick();
    inc = 1'b0;
  endtask

  function automatic int unsigned bcd2int(input logic [15:0] v);
    int unsigned n;
    n = 0;
    for (int i = 3; i >= 0; i--) n = n * 10 + int'(v[i*4 +: 4]);
    return n;
  endfunction

  task automatic load_score(input logic [15:0] v);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    do_incs(bcd2int(v));
    x = 10'd0; y = 10'd0;
    tick();
  endtask

  task automatic show(input int unsigned vx, input int unsigned vy);
    x = 10'(vx); y = 10'(vy);
    tick();
    tick();
  endtask

  initial begin
    logic [15:0] cur_set;
    logic        e1, e0;

    rst_n = 1'b0; x = 10'd5; y = 10'd5; pos_x = 10'd200; pos_y = 10'd100;
    enable = 1'b1; inc = 1'b0; clr = 1'b0;

    // reset state
    #1;
    check("rst_hit", 32'(hit), 0);
    check("rst_rgb", 32'({r, g, b}), 0);
    check("rst_score", 32'(score), 0);
    check("rst_sat", 32'(sat), 0);
    #11 rst_n = 1'b1;
    tick();

    // count to 1234, then clr wins over a simultaneous inc
    do_incs(1234);
    check("cnt_1234", 32'(score), 32'h1234);
    clr = 1'b1; inc = 1'b1;
    tick();
    clr = 1'b0; inc = 1'b0;
    check("cnt_clr_score", 32'(score), 0);
    check("cnt_clr_sat", 32'(sat), 0);

    // saturation
    do_incs(9999);
    check("sat_9999", 32'(score), 32'h9999);
    check("sat_9999_flag", 32'(sat), 0);
    inc = 1'b1;
    tick();
    check("sat_10000_score", 32'(score), 32'h9999);
    check("sat_10000_flag", 32'(sat), 1);
    tick();
    tick();
    inc = 1'b0;
    check("sat_hold_score", 32'(score), 32'h9999);
    check("sat_hold_flag", 32'(sat), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sat_clr_score", 32'(score), 0);
    check("sat_clr_flag", 32'(sat), 0);

    // rendering vectors: {snapshot, x, y, pos_x, pos_y, enable, hit(lz), hit(no lz)}
    add(16'h0000, 296, 100, 200, 100, 1, 1, 1);
    add(16'h0000, 327, 101, 200, 100, 1, 1, 1);
    add(16'h0000, 200, 100, 200, 100, 1, 0, 1);
    add(16'h0000, 295, 100, 200, 100, 1, 0, 1);
    add(16'h0000, 328, 100, 200, 100, 1, 0, 0);
    add(16'h0000, 199, 100, 200, 100, 1, 0, 0);
    add(16'h0000, 310, 120, 200, 100, 1, 0, 0);
    add(16'h0000, 296, 163, 200, 100, 1, 1, 1);
    add(16'h0000, 296, 164, 200, 100, 1, 0, 0);
    add(16'h0000, 311, 131, 200, 100, 1, 0, 0);
    add(16'h0000, 296, 100, 200, 100, 0, 0, 0);
    add(16'h0000, 999, 100, 1000, 100, 1, 0, 0);
    add(16'h0000, 1000, 100, 1000, 100, 1, 0, 1);
    add(16'h0000, 1023, 100, 1000, 100, 1, 0, 1);
    add(16'h0000, 80, 100, 1000, 100, 1, 0, 0);
    add(16'h0000, 1000, 10, 1000, 1000, 1, 0, 0);
    add(16'h0120, 232, 100, 200, 100, 1, 0, 0);
    add(16'h0120, 232, 163, 200, 100, 1, 1, 1);
    add(16'h0120, 247, 130, 200, 100, 1, 1, 1);
    add(16'h0120, 240, 130, 200, 100, 1, 0, 0);
    add(16'h0120, 200, 100, 200, 100, 1, 0, 1);
    add(16'h0120, 264, 131, 200, 100, 1, 1, 1);
    add(16'h0120, 264, 150, 200, 100, 1, 1, 1);
    add(16'h0120, 295, 150, 200, 100, 1, 0, 0);
    add(16'h0120, 295, 110, 200, 100, 1, 1, 1);
    add(16'h0120, 264, 110, 200, 100, 1, 0, 0);
    add(16'h0120, 296, 100, 200, 100, 1, 1, 1);

    cur_set = 16'hFFFF;
    foreach (tv[k]) begin
      if (tv[k].set != cur_set) begin
        load_score(tv[k].set);
        cur_set = tv[k].set;
      end
      pos_x = tv[k].px; pos_y = tv[k].py; enable = tv[k].en;
      show(int'(tv[k].x), int'(tv[k].y));
      check($sformatf("vec%0d_hit", k), 32'(hit), 32'(tv[k].h1));
      check($sformatf("vec%0d_rgb", k), 32'({r, g, b}), tv[k].h1 ? 32'hFFFFFF : 0);
      check($sformatf("vec%0d_hit_nolz", k), 32'(hit0), 32'(tv[k].h0));
    end
    pos_x = 10'd200; pos_y = 10'd100; enable = 1'b1;

    // tearing: score moves at once, rendering waits for frame start
    x = 10'd100; y = 10'd50; inc = 1'b1;
    tick();
    inc = 1'b0;
    check("tear_score", 32'(score), 32'h0121);
    show(296, 100);
    check("tear_before", 32'(hit), 1);
    x = 10'd0; y = 10'd0;
    tick();
    show(296, 100);
    check("tear_after", 32'(hit), 0);
    show(264, 100);
    check("tear_after_d2", 32'(hit), 1);

    // streaming line y=100 over snapshot 0121: output lags x by exactly 2
    y = 10'd100;
    for (int k = 0; k <= 640; k++) begin
      if (k < 640) x = 10'(k);
      tick();
      if (k >= 1) begin
        e1 = (k - 1 >= 264) && (k - 1 <= 295);
        e0 = e1 || ((k - 1 >= 200) && (k - 1 <= 231));
        check($sformatf("stream_x%0d", k - 1), 32'(hit), 32'(e1));
        check($sformatf("stream_nolz_x%0d", k - 1), 32'(hit0), 32'(e0));
      end
    end

    // asynchronous reset mid-frame
    show(264, 100);
    check("prerst_hit", 32'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hit", 32'(hit), 0);
    check("arst_rgb", 32'({r, g, b}), 0);
    check("arst_score", 32'(score), 0);
    check("arst_sat", 32'(sat), 0);
    check("arst_hit_nolz", 32'(hit0), 0);
    #2 rst_n = 1'b1;
    x = 10'd0; y = 10'd0;
    tick();
    show(296, 100);
    check("postrst_lsd", 32'(hit), 1);
    check("postrst_lsd_nolz", 32'(hit0), 1);
    show(264, 100);
    check("postrst_blank", 32'(hit), 0);
    check("postrst_noblank", 32'(hit0), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
